// File: rtl/strv32i_mem_pkg.sv
// Shared constants and types for the STRV32I data-memory responder.
// Lane geometry and the error-tracker state encoding live here.
package strv32i_mem_pkg;

  localparam int DATA_W     = 32;
  localparam int BYTE_LANES = 4;
  localparam int MASK_W     = 4;

  typedef enum logic {
    ERR_IDLE = 1'b0,
    ERR_HELD = 1'b1
  } err_state_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Core <-> data-memory port bundle.
// The core drives master, the responder implements slave.
interface dmem_responder_if;
  import strv32i_mem_pkg::*;

  logic [DATA_W-1:0] dm_addr_in;
  logic [DATA_W-1:0] dm_wdata_in;
  logic [MASK_W-1:0] dm_wr_mask_in;
  logic              dm_wr_req_in;
  logic              err_clr_in;
  logic [DATA_W-1:0] dm_rdata_out;
  logic              err_out;
  logic [DATA_W-1:0] err_addr_out;
  logic [DATA_W-1:0] wr_count_out;

  modport master (
    output dm_addr_in, dm_wdata_in,
    output dm_wr_mask_in, dm_wr_req_in,
    output err_clr_in,
    input  dm_rdata_out, err_out,
    input  err_addr_out, wr_count_out
  );

  modport slave (
    input  dm_addr_in, dm_wdata_in,
    input  dm_wr_mask_in, dm_wr_req_in,
    input  err_clr_in,
    output dm_rdata_out, err_out,
    output err_addr_out, wr_count_out
  );

endinterface

// File: rtl/dmem_bank.sv
// One byte lane of the data RAM.
// Synchronous read returns the pre-write contents; the top bypasses.
module dmem_bank #(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk_in,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
  input  logic [7:0]                     wdata,
  output logic [7:0]                     rdata
);

  logic [7:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_in) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-masked writes, 1-cycle registered reads,
// sticky out-of-range tracking and a committed-write counter.
module dmem_responder
  import strv32i_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic            clk_in,
  input logic            rst_in,
  dmem_responder_if.slave bus
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;

  // 33-bit offset: addresses below BASE wrap to >= 2^32, never in range
  logic [32:0]       off;
  logic              in_range;
  logic [AW-1:0]     idx;
  logic [MASK_W-1:0] we;
  logic [DATA_W-1:0] bank_q;

  assign off      = {1'b0, bus.dm_addr_in} - {1'b0, BASE_ADDR};
  assign in_range = off < SPAN;
  assign idx      = off[AW+1:2];
  assign we       = bus.dm_wr_mask_in &
                    {MASK_W{bus.dm_wr_req_in & in_range & ~rst_in}};

  for (genvar l = 0; l < BYTE_LANES; l++) begin : g_lane
    dmem_bank #(
      .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bank (
      .clk_in(clk_in),
      .we    (we[l]),
      .addr  (idx),
      .wdata (bus.dm_wdata_in[8*l +: 8]),
      .rdata (bank_q[8*l +: 8])
    );
  end

  logic              hit_q;
  logic [MASK_W-1:0] byp_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wr_count;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      hit_q    <= 1'b0;
      byp_q    <= '0;
      wdata_q  <= '0;
      wr_count <= '0;
    end else begin
      hit_q   <= in_range;
      byp_q   <= we;
      wdata_q <= bus.dm_wdata_in;
      if (|we) wr_count <= wr_count + 32'd1;
    end
  end

  // Write-first: lanes written last cycle come from the captured store data
  always_comb begin
    bus.dm_rdata_out = '0;
    if (hit_q) begin
      for (int l = 0; l < BYTE_LANES; l++) begin
        bus.dm_rdata_out[8*l +: 8] = byp_q[l] ? wdata_q[8*l +: 8]
                                              : bank_q[8*l +: 8];
      end
    end
  end

  err_state_t        err_state, err_state_nx;
  logic [DATA_W-1:0] err_addr, err_addr_nx;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      err_state <= ERR_IDLE;
      err_addr  <= '0;
    end else begin
      err_state <= err_state_nx;
      err_addr  <= err_addr_nx;
    end
  end

  always_comb begin
    err_state_nx = err_state;
    err_addr_nx  = err_addr;
    unique case (err_state)
      ERR_IDLE: begin
        if (bus.err_clr_in) begin
          err_addr_nx = '0;
        end else if (!in_range) begin
          err_state_nx = ERR_HELD;
          err_addr_nx  = bus.dm_addr_in;
        end
      end
      ERR_HELD: begin
        if (bus.err_clr_in) begin
          err_state_nx = ERR_IDLE;
          err_addr_nx  = '0;
        end
      end
      default: err_state_nx = ERR_IDLE;
    endcase
  end

  assign bus.err_out      = (err_state == ERR_HELD);
  assign bus.err_addr_out = err_addr;
  assign bus.wr_count_out = wr_count;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a word model predicts each read,
// the error tracker and the write counter.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0000_1000;

  typedef struct {
    logic [31:0] exp;
    logic [3:0]  care;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dmem_responder_if bus();

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [DEPTH];
  logic [3:0]  kn  [DEPTH];
  logic [31:0] m_cnt;
  logic [31:0] m_eaddr;
  logic        m_err;
  exp_t        sbq [$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lanes(logic [3:0] c);
    return {{8{c[3]}}, {8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
  endfunction

  // Called at a falling edge; drives one access, checks it one cycle later
  task automatic step(string tag, logic [31:0] a, logic [31:0] d,
                      logic [3:0] m, logic r, logic c);
    exp_t        e;
    logic        inr;
    int          i;
    logic [31:0] nw;
    logic [31:0] cm;
    bus.dm_addr_in    = a;
    bus.dm_wdata_in   = d;
    bus.dm_wr_mask_in = m;
    bus.dm_wr_req_in  = r;
    bus.err_clr_in    = c;
    inr = ({1'b0, a} >= {1'b0, BASE}) &&
          ({1'b0, a} < ({1'b0, BASE} + 33'(DEPTH * 4)));
    e.exp  = 32'h0;
    e.care = 4'hF;
    if (inr) begin
      i  = int'((a - BASE) >> 2);
      nw = mdl[i];
      for (int b = 0; b < 4; b++)
        if (r && m[b]) nw[8*b +: 8] = d[8*b +: 8];
      e.exp  = nw;
      e.care = kn[i] | (r ? m : 4'h0);
      if (r && m != 4'h0) begin
        mdl[i] = nw;
        kn[i]  = kn[i] | m;
        m_cnt  = m_cnt + 32'd1;
      end
    end
    if (c) begin
      m_err   = 1'b0;
      m_eaddr = 32'h0;
    end else if (!inr && !m_err) begin
      m_err   = 1'b1;
      m_eaddr = a;
    end
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e  = sbq.pop_front();
    cm = lanes(e.care);
    if (e.care != 4'h0)
      check({tag, "/rdata"}, bus.dm_rdata_out & cm, e.exp & cm);
    check({tag, "/err"}, 32'(bus.err_out), 32'(m_err));
    check({tag, "/eaddr"}, bus.err_addr_out, m_eaddr);
    check({tag, "/cnt"}, bus.wr_count_out, m_cnt);
  endtask

  initial begin
    for (int k = 0; k < int'(DEPTH); k++) begin
      mdl[k] = 32'h0;
      kn[k]  = 4'h0;
    end
    m_cnt   = 32'h0;
    m_eaddr = 32'h0;
    m_err   = 1'b0;
    bus.dm_addr_in    = 32'h0;
    bus.dm_wdata_in   = 32'h0;
    bus.dm_wr_mask_in = 4'h0;
    bus.dm_wr_req_in  = 1'b0;
    bus.err_clr_in    = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("rst/rdata", bus.dm_rdata_out, 32'h0);
    check("rst/err", 32'(bus.err_out), 32'h0);
    check("rst/eaddr", bus.err_addr_out, 32'h0);
    check("rst/cnt", bus.wr_count_out, 32'h0);
    rst = 1'b0;

    step("wr_full",  BASE + 32'h10, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
    step("rd_full",  BASE + 32'h10, 32'h0, 4'h0, 1'b0, 1'b0);
    step("pre_mask", BASE + 32'h20, 32'h11223344, 4'hF, 1'b1, 1'b0);
    step("wr_mask",  BASE + 32'h20, 32'hAABBCCDD, 4'b0101, 1'b1, 1'b0);
    step("rd_mask",  BASE + 32'h22, 32'h0, 4'h0, 1'b0, 1'b0);
    step("pre_rdw",  BASE + 32'h30, 32'h12345678, 4'hF, 1'b1, 1'b0);
    step("rdw",      BASE + 32'h30, 32'h000000FF, 4'b0001, 1'b1, 1'b0);
    step("rd_rdw",   BASE + 32'h30, 32'h0, 4'h0, 1'b0, 1'b0);
    step("mask0",    BASE + 32'h30, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b0);
    step("wr_last",  BASE + 32'h3C, 32'hA5A5_5A5A, 4'hF, 1'b1, 1'b0);
    step("rd_last",  BASE + 32'h3F, 32'h0, 4'h0, 1'b0, 1'b0);
    step("wr_first", BASE, 32'h0BAD_F00D, 4'hF, 1'b1, 1'b0);
    step("rd_first", BASE, 32'h0, 4'h0, 1'b0, 1'b0);

    step("oor_wr",   BASE + 32'h40, 32'h5555_5555, 4'hF, 1'b1, 1'b0);
    step("oor_rd",   BASE - 32'h4, 32'h0, 4'h0, 1'b0, 1'b0);
    step("oor_clr",  32'h0000_2000, 32'h0, 4'h0, 1'b0, 1'b1);
    step("oor_top",  32'hFFFF_FFFC, 32'h1, 4'hF, 1'b1, 1'b0);
    step("clr_ok",   BASE + 32'h10, 32'h0, 4'h0, 1'b0, 1'b1);

    force dut.wr_count = 32'hFFFF_FFFD;
    m_cnt = 32'hFFFF_FFFD;
    #1 release dut.wr_count;
    step("wrap1", BASE + 32'h4, 32'h0000_0001, 4'hF, 1'b1, 1'b0);
    step("wrap2", BASE + 32'h8, 32'h0000_0002, 4'hF, 1'b1, 1'b0);
    step("wrap3", BASE + 32'hC, 32'h0000_0003, 4'hF, 1'b1, 1'b0);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      a = BASE - 32'd8 + 32'(4 * $urandom_range(0, 19))
          + 32'($urandom_range(0, 3));
      step("rand", a, $urandom, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    step("burst1", BASE + 32'h14, 32'h1111_1111, 4'hF, 1'b1, 1'b0);
    step("burst2", BASE + 32'h18, 32'h2222_2222, 4'hF, 1'b1, 1'b0);
    step("oor_pre", BASE + 32'h80, 32'h0, 4'h0, 1'b0, 1'b0);
    bus.dm_addr_in    = BASE + 32'h14;
    bus.dm_wdata_in   = 32'hCAFE_F00D;
    bus.dm_wr_mask_in = 4'hF;
    bus.dm_wr_req_in  = 1'b1;
    bus.err_clr_in    = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst/rdata", bus.dm_rdata_out, 32'h0);
    check("arst/err", 32'(bus.err_out), 32'h0);
    check("arst/eaddr", bus.err_addr_out, 32'h0);
    check("arst/cnt", bus.wr_count_out, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    m_cnt   = 32'h0;
    m_err   = 1'b0;
    m_eaddr = 32'h0;
    step("post_rd1", BASE + 32'h14, 32'h0, 4'h0, 1'b0, 1'b0);
    step("post_rd2", BASE + 32'h18, 32'h0, 4'h0, 1'b0, 1'b0);
    step("post_wr",  BASE + 32'h14, 32'h7777_0000, 4'b1100, 1'b1, 1'b0);
    step("post_rd3", BASE + 32'h14, 32'h0, 4'h0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
